// File: rtl/csr_regfile.sv
// Machine-mode CSR file for the RV64 pipeline: EX read port, WB write port, trap/mret
// state updates and a one-cycle registered redirect to fetch. Optional: CSR_COUNTERS_EN.
module csr_regfile #(
   parameter int               XLEN        = 64,
   parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
   parameter logic [XLEN-1:0]  HARTID      = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            illegal_addr,
   input  logic            csr_we,
   input  logic [11:0]     csr_waddr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret_valid,
   input  logic            instret_inc,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            mstatus_mie
);
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MHARTID  = 12'hF14;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;

   typedef enum logic {IDLE, REDIR} state_t;

   state_t          state;
   logic            mie_q, mpie_q;
   logic [XLEN-1:0] mie_reg_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [XLEN-1:0] mstatus_rd, fwd_val;
   logic            rd_impl, wr_impl, fwd;

   function automatic logic is_impl(input logic [11:0] a);
      case (a)
         A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC,
         A_MCAUSE, A_MTVAL, A_MHARTID: is_impl = 1'b1;
`ifdef CSR_COUNTERS_EN
         A_MCYCLE, A_MINSTRET:         is_impl = 1'b1;
`endif
         default:                      is_impl = 1'b0;
      endcase
   endfunction

   // Value a CSR would hold after a write of v; shared by the forward and commit paths.
   function automatic logic [XLEN-1:0] legalize(input logic [11:0] a, input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      r = v;
      case (a)
         A_MSTATUS: begin
            r        = '0;
            r[3]     = v[3];
            r[7]     = v[7];
            r[12:11] = 2'b11;
         end
         A_MTVEC, A_MEPC: r[1:0] = 2'b00;
         default: ;
      endcase
      return r;
   endfunction

`ifdef CSR_COUNTERS_EN
   logic [XLEN-1:0] mcycle_q, minstret_q;
`else
   logic unused_instret;
   assign unused_instret = instret_inc;
`endif

   always_comb begin
      mstatus_rd        = '0;
      mstatus_rd[3]     = mie_q;
      mstatus_rd[7]     = mpie_q;
      mstatus_rd[12:11] = 2'b11;
   end

   assign rd_impl = is_impl(csr_raddr);
   assign wr_impl = is_impl(csr_waddr) && (csr_waddr != A_MHARTID);
   assign fwd     = csr_we && wr_impl && (csr_waddr == csr_raddr);
   assign fwd_val = legalize(csr_waddr, csr_wdata);

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         A_MSTATUS:  csr_rdata = mstatus_rd;
         A_MIE:      csr_rdata = mie_reg_q;
         A_MTVEC:    csr_rdata = mtvec_q;
         A_MSCRATCH: csr_rdata = mscratch_q;
         A_MEPC:     csr_rdata = mepc_q;
         A_MCAUSE:   csr_rdata = mcause_q;
         A_MTVAL:    csr_rdata = mtval_q;
         A_MHARTID:  csr_rdata = HARTID;
`ifdef CSR_COUNTERS_EN
         A_MCYCLE:   csr_rdata = mcycle_q;
         A_MINSTRET: csr_rdata = minstret_q;
`endif
         default:    csr_rdata = '0;
      endcase
      if (fwd) csr_rdata = fwd_val;
   end

   assign illegal_addr = !rd_impl;
   assign mstatus_mie  = mie_q;

   // Trap beats mret beats a WB write; the losers are dropped entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mie_reg_q  <= '0;
         mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= '0;
         minstret_q <= '0;
`endif
      end else begin
`ifdef CSR_COUNTERS_EN
         mcycle_q <= mcycle_q + 1'b1;
         if (instret_inc) minstret_q <= minstret_q + 1'b1;
`endif
         if (trap_valid) begin
            mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
         end else if (mret_valid) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end else if (csr_we) begin
            case (csr_waddr)
               A_MSTATUS: begin
                  mie_q  <= csr_wdata[3];
                  mpie_q <= csr_wdata[7];
               end
               A_MIE:      mie_reg_q  <= csr_wdata;
               A_MTVEC:    mtvec_q    <= fwd_val;
               A_MSCRATCH: mscratch_q <= csr_wdata;
               A_MEPC:     mepc_q     <= fwd_val;
               A_MCAUSE:   mcause_q   <= csr_wdata;
               A_MTVAL:    mtval_q    <= csr_wdata;
`ifdef CSR_COUNTERS_EN
               A_MCYCLE:   mcycle_q   <= csr_wdata;
               A_MINSTRET: minstret_q <= csr_wdata;
`endif
               default: ;
            endcase
         end
      end
   end

   // Redirect target is captured from pre-edge mtvec/mepc, so same-cycle writes never leak in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         redirect_pc <= '0;
      end else if (trap_valid) begin
         state       <= REDIR;
         redirect_pc <= mtvec_q;
      end else if (mret_valid) begin
         state       <= REDIR;
         redirect_pc <= mepc_q;
      end else begin
         state       <= IDLE;
         redirect_pc <= '0;
      end
   end

   assign redirect_valid = (state == REDIR);

endmodule
